// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 convolution datapath: window geometry,
// pixel type and the flattened-window element index.
package conv_pkg;

    localparam int PIX_W     = 8;
    localparam int MAT_N     = 3;
    localparam int WIN_ELEMS = MAT_N * MAT_N;

    typedef logic [PIX_W-1:0] pixel_t;

    // Row-major element index inside a flattened window; r=0 is the top line.
    function automatic int win_idx(input int r, input int c);
        return r * MAT_N + c;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// One line of pixel storage. Combinational read of the addressed entry
// returns the old contents while the same entry is rewritten at the edge.
module line_buffer #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 64,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

endmodule

// File: rtl/sliding_window_gen.sv
// Builds 3x3 valid-only windows from a raster pixel stream. The window
// register is the output register, so it only shifts when the output is free.
module sliding_window_gen
    import conv_pkg::*;
#(
    parameter int IMAGE_WIDTH = 8,
    parameter int MATRIX_SIZE = 3,
    parameter int IMG_COLS    = 64,
    parameter int IMG_ROWS    = 64
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [IMAGE_WIDTH-1:0]               pix_in,
    input  logic                                 pix_valid,
    output logic                                 pix_ready,
    output logic [IMAGE_WIDTH*MATRIX_SIZE**2-1:0] win_out,
    output logic                                 win_valid,
    input  logic                                 win_ready,
    output logic                                 win_last
);

    localparam int CW    = $clog2(IMG_COLS);
    localparam int RW    = $clog2(IMG_ROWS);
    localparam int N_LB  = MATRIX_SIZE - 1;

    if (MATRIX_SIZE != 3 || IMG_COLS < MATRIX_SIZE || IMG_ROWS < MATRIX_SIZE) begin : g_param_err
        $error("sliding_window_gen: MATRIX_SIZE must be 3 and the frame at least 3x3");
    end

    logic [CW-1:0]                            col;
    logic [RW-1:0]                            row;
    logic [WIN_ELEMS-1:0][IMAGE_WIDTH-1:0]    win_q;
    logic [N_LB-1:0][IMAGE_WIDTH-1:0]         lb_rd;
    logic                                     accept;
    logic                                     col_last;
    logic                                     row_last;

    assign pix_ready = !win_valid || win_ready;
    assign accept    = pix_valid && pix_ready;
    assign col_last  = (col == CW'(IMG_COLS - 1));
    assign row_last  = (row == RW'(IMG_ROWS - 1));
    assign win_out   = win_q;

    // lb_rd[0] is the previous line, lb_rd[1] the one before; each pushes
    // its old entry down to the next buffer as the new pixel is written.
    for (genvar i = 0; i < N_LB; i++) begin : g_lb
        logic [IMAGE_WIDTH-1:0] wd;
        if (i == 0) begin : g_first
            assign wd = pix_in;
        end else begin : g_next
            assign wd = lb_rd[i-1];
        end
        line_buffer #(
            .WIDTH (IMAGE_WIDTH),
            .DEPTH (IMG_COLS)
        ) u_lb (
            .clk   (clk),
            .we    (accept),
            .addr  (col),
            .wdata (wd),
            .rdata (lb_rd[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col       <= '0;
            row       <= '0;
            win_q     <= '0;
            win_valid <= 1'b0;
            win_last  <= 1'b0;
        end else if (accept) begin
            for (int r = 0; r < MATRIX_SIZE; r++) begin
                for (int c = 0; c < MATRIX_SIZE - 1; c++) begin
                    win_q[win_idx(r, c)] <= win_q[win_idx(r, c + 1)];
                end
            end
            win_q[win_idx(0, 2)] <= lb_rd[1];
            win_q[win_idx(1, 2)] <= lb_rd[0];
            win_q[win_idx(2, 2)] <= pix_in;

            // Columns 0/1 of a line still hold the previous line's tail.
            win_valid <= (row >= RW'(MATRIX_SIZE - 1)) && (col >= CW'(MATRIX_SIZE - 1));
            win_last  <= row_last && col_last;

            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end else if (win_ready) begin
            win_valid <= 1'b0;
            win_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sliding_window_gen.sv
// Self-checking bench: a frame-array scoreboard predicts every window from
// the pixels accepted so far; directed sections check the named scenarios.
module tb_sliding_window_gen;

    localparam int C = 5;
    localparam int R = 4;

    localparam logic [71:0] W0 = 72'h22_21_20_12_11_10_02_01_00;
    localparam logic [71:0] W1 = 72'h23_22_21_13_12_11_03_02_01;
    localparam logic [71:0] W3 = 72'h32_31_30_22_21_20_12_11_10;

    typedef struct packed {
        logic [71:0] w;
        logic        last;
    } win_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  pix_in;
    logic        pix_valid;
    logic        pix_ready;
    logic [71:0] win_out;
    logic        win_valid;
    logic        win_ready;
    logic        win_last;

    int errs   = 0;
    int checks = 0;
    int cyc    = 0;
    int rdy_mode;
    int pr_low;

    win_t        exp_q[$];
    logic [7:0]  frame [R][C];
    int          n_acc;
    logic [71:0] seen_w[$];
    logic        seen_l[$];
    int          seen_cyc[$];
    logic [71:0] prev_w;
    logic        prev_l;
    logic        prev_hold;

    sliding_window_gen #(
        .IMAGE_WIDTH (8),
        .MATRIX_SIZE (3),
        .IMG_COLS    (C),
        .IMG_ROWS    (R)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pix_in    (pix_in),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .win_out   (win_out),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .win_last  (win_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (rdy_mode == 0) win_ready = 1'b1;
        else if (rdy_mode == 1) win_ready = ($urandom_range(99) < 60);
    end

    // Scoreboard: window (r,c) is frame rows r-2..r, cols c-2..c.
    win_t mon_e;
    int   mon_r, mon_c;
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            n_acc     = 0;
            prev_hold = 1'b0;
        end else begin
            chk("win_valid", win_valid, exp_q.size() != 0);
            chk("pix_ready", pix_ready, !win_valid || win_ready);
            if (!pix_ready) pr_low++;
            if (prev_hold) begin
                chk("hold_out", win_out, prev_w);
                chk("hold_last", win_last, prev_l);
            end
            if (win_valid && win_ready && exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("win_out", win_out, mon_e.w);
                chk("win_last", win_last, mon_e.last);
                seen_w.push_back(win_out);
                seen_l.push_back(win_last);
                seen_cyc.push_back(cyc);
            end
            prev_hold = win_valid && !win_ready;
            prev_w    = win_out;
            prev_l    = win_last;
            if (pix_valid && pix_ready) begin
                mon_r = n_acc / C;
                mon_c = n_acc % C;
                frame[mon_r][mon_c] = pix_in;
                if (mon_r >= 2 && mon_c >= 2) begin
                    for (int i = 0; i < 3; i++)
                        for (int j = 0; j < 3; j++)
                            mon_e.w[(i*3+j)*8 +: 8] = frame[mon_r-2+i][mon_c-2+j];
                    mon_e.last = (mon_r == R-1) && (mon_c == C-1);
                    exp_q.push_back(mon_e);
                end
                n_acc = (n_acc + 1) % (C * R);
            end
        end
    end

    task automatic push(input logic [7:0] v, input int gap);
        int  t;
        logic acc;
        while (gap > 0 && $urandom_range(99) < gap) begin
            pix_valid = 1'b0;
            @(posedge clk); #1;
        end
        pix_valid = 1'b1;
        pix_in    = v;
        t = 0;
        forever begin
            @(negedge clk);
            acc = pix_ready;
            @(posedge clk); #1;
            if (acc) break;
            t++;
            if (t > 500) begin
                chk("push_timeout", 1, 0);
                break;
            end
        end
    endtask

    task automatic send_frame(input bit rand_pix, input int gap);
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                push(rand_pix ? 8'($urandom) : 8'(r*16 + c), gap);
        pix_valid = 1'b0;
    endtask

    task automatic drain();
        rdy_mode = 0;
        repeat (6) @(posedge clk);
        #1;
        chk("drain_empty", exp_q.size(), 0);
    endtask

    function automatic int count_last(input int b, input int n);
        int k = 0;
        for (int i = b; i < b + n && i < seen_l.size(); i++) if (seen_l[i]) k++;
        return k;
    endfunction

    int b;

    initial begin
        rst = 1'b1; pix_valid = 1'b0; pix_in = '0; win_ready = 1'b1;
        rdy_mode = 0; pr_low = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", win_valid, 0);
        chk("rst_last", win_last, 0);
        chk("rst_out", win_out, 0);
        @(posedge clk); #1;

        // Basic window and line wrap
        b = seen_w.size();
        send_frame(0, 0);
        drain();
        chk("basic_cnt", seen_w.size() - b, 6);
        chk("basic_w0", seen_w[b], W0);
        chk("wrap_w3", seen_w[b+3], W3);
        chk("basic_lastcnt", count_last(b, 6), 1);
        chk("basic_last5", seen_l[b+5], 1);
        chk("basic_last_px", seen_w[b+5][71:64], 8'h34);

        // Backpressure on the first window
        b = seen_w.size();
        rdy_mode = 2;
        win_ready = 1'b1;
        fork
            send_frame(0, 0);
            begin
                int t;
                t = 0;
                while (!win_valid && t < 500) begin
                    @(posedge clk); #1;
                    t++;
                end
                chk("bp_valid", win_valid, 1);
                win_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    chk("bp_pix_ready", pix_ready, 0);
                    chk("bp_hold", win_out, W0);
                    @(posedge clk); #1;
                end
                win_ready = 1'b1;
                rdy_mode = 0;
            end
        join
        drain();
        chk("bp_cnt", seen_w.size() - b, 6);
        chk("bp_w1", seen_w[b+1], W1);

        // Reset mid-frame after pixel 0x13
        for (int i = 0; i < 9; i++) push(8'((i / C) * 16 + (i % C)), 0);
        pix_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_valid", win_valid, 0);
        @(posedge clk); #1;
        b = seen_w.size();
        send_frame(0, 0);
        drain();
        chk("rst_cnt", seen_w.size() - b, 6);
        chk("rst_w0", seen_w[b], W0);
        chk("rst_w3", seen_w[b+3], W3);
        chk("rst_lastcnt", count_last(b, 6), 1);

        // Back-to-back frames at full throughput
        b = seen_w.size();
        pr_low = 0;
        send_frame(0, 0);
        send_frame(1, 0);
        drain();
        chk("b2b_cnt", seen_w.size() - b, 12);
        chk("b2b_lastcnt", count_last(b, 12), 2);
        chk("tput_ready_low", pr_low, 0);
        if (seen_w.size() - b >= 12) begin
            for (int i = 0; i < 11; i++)
                if (i % 3 != 2) chk("tput_gap", seen_cyc[b+i+1] - seen_cyc[b+i], 1);
            chk("f2_first_gap", seen_cyc[b+6] - seen_cyc[b+5], 13);
        end

        // Random pixels, input gaps and output backpressure
        b = seen_w.size();
        rdy_mode = 1;
        repeat (4) send_frame(1, 30);
        drain();
        chk("rand_cnt", seen_w.size() - b, 24);
        chk("rand_lastcnt", count_last(b, 24), 4);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/sliding_window_gen.md
Name: sliding_window_gen

Overview:
- Producer side of the 3×3 convolution datapath.
- Accepts a raster-order pixel stream (one pixel per beat, ready/valid) and builds the MATRIX_SIZE×MATRIX_SIZE windows.
- Emits each window flattened in exactly the packing the convolution block consumes on its in_matrix input.
- Uses valid-only convolution: no padding; a window is emitted only when all of its pixels lie inside the frame.

Parameters:
- IMAGE_WIDTH, 8: pixel width in bits (unsigned).
- MATRIX_SIZE, 3: window edge length; the block supports 3 only, and other values are an elaboration error.
- IMG_COLS, 64: pixels per line; must be >= MATRIX_SIZE.
- IMG_ROWS, 64: lines per frame; must be >= MATRIX_SIZE.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- pix_in, input, IMAGE_WIDTH: input pixel.
- pix_valid, input, 1: pix_in is valid.
- pix_ready, output, 1: block accepts a pixel this cycle.
- win_out, output, IMAGE_WIDTH*MATRIX_SIZE**2: flattened window.
- win_valid, output, 1: win_out holds a valid window.
- win_ready, input, 1: downstream accepts the window.
- win_last, output, 1: qualifies the final window of a frame.

Behaviour:
- Reset: win_valid=0, win_last=0, win_out=0, and the column and row counters = 0. Line-buffer contents are not reset; row gating makes them don't-care.
- Reset mid-frame: the partial frame is discarded. The next accepted pixel is (row 0, col 0).
- Handshake: pix_ready = !win_valid || win_ready, combinational.
- A pixel is accepted when pix_valid && pix_ready. Nothing changes on cycles with no accept, except that win_valid clears when a held window is consumed.
- Window packing: element index k = r*3 + c, stored at win_out[k*IMAGE_WIDTH +: IMAGE_WIDTH].
  - r=0 is the oldest (top) line; c=0 is the leftmost (oldest) column.
  - Element 8 is the newest accepted pixel.
- On accept of pixel p at position (row, col):
  - Form the new column {top = line_buf1[col], mid = line_buf0[col], bot = p}.
  - Write line_buf1[col] <= line_buf0[col] and line_buf0[col] <= p.
  - Shift the window register left by one column: column c takes column c+1, and column 2 takes the new column.
- The window register is the output register; no extra copy exists. The stall rule guarantees it only shifts when the output is free.
- win_valid timing: win_valid <= 1 on the cycle after an accept with row >= 2 && col >= 2. Otherwise win_valid <= 0 once consumed (win_valid && win_ready).
  - Latency is 1 cycle from the accept edge to win_valid.
- win_last is set together with win_valid for the pixel at (IMG_ROWS-1, IMG_COLS-1). It has the same lifetime as win_valid.
- Windows emitted per frame: (IMG_COLS-2)*(IMG_ROWS-2).
- Counters:
  - col wraps from IMG_COLS-1 to 0 and then increments row.
  - row wraps from IMG_ROWS-1 to 0.
  - The next frame follows back-to-back with no idle cycle required.
- Window columns left over from the previous line or frame are flushed naturally: col < 2 suppresses output.
- Simultaneous consume and accept: win_ready=1 with win_valid=1 and pix_valid=1 must sustain 1 window per cycle with no bubble.
- While win_valid && !win_ready: pix_ready=0, and win_out and win_last hold stable.

Decomposition:
- Shared package conv_pkg holds:
  - WIN_ELEMS = MATRIX_SIZE**2;
  - the win_idx(r,c) = r*MATRIX_SIZE + c function, shared with the convolution block and the kernel packing;
  - the pixel_t typedef, logic [IMAGE_WIDTH-1:0].
- One sub-module, line_buffer #(WIDTH, DEPTH):
  - single read/write address, with the read returning the old data in the same cycle;
  - instantiated twice, for line_buf0 and line_buf1.
- Counters, window register and handshake logic live in the top module.

Test Plan:
- Basic window: IMG_COLS=5, IMG_ROWS=4, pixel(r,c) = r*16+c, streamed with win_ready=1.
  - The first win_valid comes 1 cycle after pixel 0x22 is accepted.
  - win_out elements 0..8 = 00,01,02,10,11,12,20,21,22.
  - Exactly 6 windows are emitted.
  - win_last is asserted only on the window whose element 8 = 0x34.
- Line wrap: same stream.
  - The window after 0x24 has element 8 = 0x32, with elements 0..8 = 10,11,12,20,21,22,30,31,32.
  - Pixels 0x30 and 0x31 produce no window.
- Backpressure: hold win_ready=0 for 5 cycles while the first window is valid.
  - pix_ready=0 throughout, and win_out stays at the 00..22 window.
  - After release, the next window is 01,02,03,11,12,13,21,22,23.
- Full throughput: pix_valid=1 and win_ready=1 constantly.
  - Windows appear on consecutive cycles within a row, with pix_ready never low.
- Reset mid-frame: assert rst after pixel 0x13.
  - win_valid=0 the next cycle.
  - Restarting the stream from 0x00 reproduces the basic-window results exactly.
- Back-to-back frames: two frames streamed with no gap.
  - Frame 2 emits its first window only after its own pixel (2,2).
  - 12 windows in total, with win_last asserted twice.
